// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
package imem_pkg;

    localparam int ADDR_W_DEFAULT = 6;
    localparam int WORD_W         = 32;
    localparam int STREAK_W       = 8;

    typedef enum logic {
        F_PRI = 1'b0,
        L_PRI = 1'b1
    } arb_state_e;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Fetch, loader and RAM-side signals of the instruction-memory arbiter.
interface imem_port_arbiter_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [WORD_W-1:0] if_rdata;
    logic              if_oob;
    logic              stall_f;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [WORD_W-1:0] ld_data;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ld_valid, ld_addr, ld_data, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_oob, stall_f,
        output ld_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, ld_valid, ld_addr, ld_data, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_oob, stall_f,
        input  ld_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_streak_ctr.sv
// Saturating count of consecutive fetch grants taken while a load waits.
module imem_streak_ctr
    import imem_pkg::*;
#(
    parameter int MAX = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                inc,
    output logic [STREAK_W-1:0] count
);
    localparam logic [STREAK_W-1:0] MAX_V = STREAK_W'(MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && count != MAX_V) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one single-port instruction RAM between Fetch reads and loader writes,
// with a streak limit so a pending load cannot be starved.
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int MAX_STREAK = 8
) (
    input logic                clk,
    input logic                reset,
    imem_port_arbiter_if.slave bus
);
    localparam logic [STREAK_W-1:0] LIM = STREAK_W'(MAX_STREAK - 1);

    arb_state_e          state;
    arb_state_e          state_n;
    logic [STREAK_W-1:0] streak;
    logic                if_gnt;
    logic                ld_ready;
    logic                inc;
    logic                clr;
    logic                rvalid;
    logic                oob;
    logic [WORD_W-1:0]   rdata_q;

    imem_streak_ctr #(.MAX(MAX_STREAK)) u_streak (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (inc),
        .count (streak)
    );

    // The switch to L_PRI is taken on the grant that fills the streak,
    // so exactly MAX_STREAK fetches precede the forced load.
    always_comb begin
        if_gnt   = 1'b0;
        ld_ready = 1'b0;
        inc      = 1'b0;
        state_n  = state;
        case (state)
            F_PRI: begin
                if (bus.if_req) begin
                    if_gnt = 1'b1;
                    inc    = bus.ld_valid;
                    if (bus.ld_valid && streak >= LIM) begin
                        state_n = L_PRI;
                    end
                end else if (bus.ld_valid) begin
                    ld_ready = 1'b1;
                end
            end
            L_PRI: begin
                state_n = F_PRI;
                if (bus.ld_valid) begin
                    ld_ready = 1'b1;
                end else begin
                    if_gnt = bus.if_req;
                end
            end
            default: state_n = F_PRI;
        endcase
        clr = ~bus.ld_valid | ld_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= F_PRI;
            rvalid  <= 1'b0;
            oob     <= 1'b0;
            rdata_q <= '0;
        end else begin
            state  <= state_n;
            rvalid <= if_gnt;
            oob    <= if_gnt & (|bus.if_addr[31:ADDR_W+2]);
            if (rvalid) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.ld_ready  = ld_ready;
    assign bus.stall_f   = bus.if_req & ~if_gnt;
    assign bus.mem_en    = if_gnt | ld_ready;
    assign bus.mem_we    = ld_ready;
    assign bus.mem_addr  = ld_ready ? bus.ld_addr : bus.if_addr[ADDR_W+1:2];
    assign bus.mem_wdata = ld_ready ? bus.ld_data : '0;
    assign bus.if_rvalid = rvalid;
    assign bus.if_oob    = oob;
    assign bus.if_rdata  = rvalid ? bus.mem_rdata : rdata_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a write-first behavioural RAM.
module tb_imem_port_arbiter;
    import imem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_port_arbiter_if #(.ADDR_W(6)) bus ();

    imem_port_arbiter #(.ADDR_W(6), .MAX_STREAK(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] ram [64];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr] <= bus.mem_wdata;
                bus.mem_rdata     <= bus.mem_wdata;
            end else begin
                bus.mem_rdata <= ram[bus.mem_addr];
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic req,
                         input logic [31:0] addr, input logic lv,
                         input logic [5:0] la, input logic [31:0] ld);
        @(posedge clk);
        #1;
        reset        = rst;
        bus.if_req   = req;
        bus.if_addr  = addr;
        bus.ld_valid = lv;
        bus.ld_addr  = la;
        bus.ld_data  = ld;
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
    endtask

    logic exp_ld;

    initial begin
        ram[0] = 32'h0000_0013;
        ram[4] = 32'hE280_0000;
        reset        = 1'b0;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h10;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 6'd5;
        bus.ld_data  = 32'hE080_2001;

        // reset held two cycles with every request high
        drive(1'b0, 1'b1, 32'h10, 1'b1, 6'd5, 32'hE080_2001);
        drive(1'b0, 1'b1, 32'h10, 1'b1, 6'd5, 32'hE080_2001);
        chk("rst_if_gnt", 32'(bus.if_gnt), 32'd1);
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("rst_rvalid", 32'(bus.if_rvalid), 32'd0);
        idle();
        chk("rst_rvalid2", 32'(bus.if_rvalid), 32'd0);
        chk("rst_rdata", bus.if_rdata, 32'h0);
        chk("idle_mem_en", 32'(bus.mem_en), 32'd0);
        chk("idle_gnt", 32'(bus.if_gnt), 32'd0);

        // fetch only
        drive(1'b1, 1'b1, 32'h10, 1'b0, 6'd0, 32'h0);
        chk("f_gnt", 32'(bus.if_gnt), 32'd1);
        chk("f_stall", 32'(bus.stall_f), 32'd0);
        chk("f_mem_we", 32'(bus.mem_we), 32'd0);
        chk("f_mem_addr", 32'(bus.mem_addr), 32'd4);
        idle();
        chk("f_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("f_rdata", bus.if_rdata, 32'hE280_0000);
        chk("f_oob", 32'(bus.if_oob), 32'd0);
        idle();
        chk("f_rvalid_off", 32'(bus.if_rvalid), 32'd0);
        chk("f_rdata_hold", bus.if_rdata, 32'hE280_0000);

        // load only, then fetch the written word
        drive(1'b1, 1'b0, 32'h0, 1'b1, 6'd5, 32'hE080_2001);
        chk("l_ready", 32'(bus.ld_ready), 32'd1);
        chk("l_mem_we", 32'(bus.mem_we), 32'd1);
        chk("l_mem_addr", 32'(bus.mem_addr), 32'd5);
        chk("l_wdata", bus.mem_wdata, 32'hE080_2001);
        chk("l_if_gnt", 32'(bus.if_gnt), 32'd0);
        drive(1'b1, 1'b1, 32'h14, 1'b0, 6'd0, 32'h0);
        chk("wf_gnt", 32'(bus.if_gnt), 32'd1);
        chk("wf_mem_addr", 32'(bus.mem_addr), 32'd5);
        idle();
        chk("wf_rdata", bus.if_rdata, 32'hE080_2001);

        // out-of-bounds fetch aliases to word 0
        drive(1'b1, 1'b1, 32'h100, 1'b0, 6'd0, 32'h0);
        chk("oob_mem_addr", 32'(bus.mem_addr), 32'd0);
        idle();
        chk("oob_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("oob_flag", 32'(bus.if_oob), 32'd1);
        chk("oob_rdata", bus.if_rdata, 32'h0000_0013);

        // contention: 8 fetches then 1 load, twice
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 1'b1, 32'h10, 1'b1, 6'd6, 32'h1111_1111);
            exp_ld = (i % 9 == 8);
            chk("ct_gnt", 32'(bus.if_gnt), 32'(!exp_ld));
            chk("ct_ld_ready", 32'(bus.ld_ready), 32'(exp_ld));
            chk("ct_stall", 32'(bus.stall_f), 32'(exp_ld));
            chk("ct_rvalid", 32'(bus.if_rvalid),
                32'(i != 0 && ((i - 1) % 9) != 8));
        end

        // load withdrawn while in load priority
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 32'h10, 1'b1, 6'd6, 32'h2222_2222);
            chk("dr_pre_gnt", 32'(bus.if_gnt), 32'd1);
        end
        drive(1'b1, 1'b1, 32'h10, 1'b0, 6'd6, 32'h0);
        chk("dr_gnt", 32'(bus.if_gnt), 32'd1);
        chk("dr_ld_ready", 32'(bus.ld_ready), 32'd0);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 32'h10, 1'b1, 6'd6, 32'h3333_3333);
            chk("dr_post_ld", 32'(bus.ld_ready), 32'(i == 8));
        end

        // load accepted during reset still writes
        idle();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 6'd7, 32'hCAFE_F00D);
        chk("rl_ready", 32'(bus.ld_ready), 32'd1);
        chk("rl_mem_we", 32'(bus.mem_we), 32'd1);
        drive(1'b1, 1'b1, 32'h1C, 1'b0, 6'd0, 32'h0);
        chk("rl_gnt", 32'(bus.if_gnt), 32'd1);
        idle();
        chk("rl_rdata", bus.if_rdata, 32'hCAFE_F00D);

        // reset mid-read with a partial streak
        idle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h10, 1'b1, 6'd6, 32'h4444_4444);
        end
        drive(1'b0, 1'b1, 32'h10, 1'b1, 6'd6, 32'h4444_4444);
        chk("rm_gnt", 32'(bus.if_gnt), 32'd1);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 32'h10, 1'b1, 6'd6, 32'h4444_4444);
            if (i == 0) begin
                chk("rm_rvalid", 32'(bus.if_rvalid), 32'd0);
            end
            chk("rm_ld_ready", 32'(bus.ld_ready), 32'(i == 8));
        end

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
